muldiv_unit: RTL
================

# muldiv_unit

Iterative multiply/divide unit with HI/LO result registers, sitting directly downstream of the register file. Operands come from the register file's two read ports. The block runs a Dbits-cycle shift-add multiply or restoring divide and holds the results in HI/LO for later move-from-HI/LO instructions. The controller stalls on `busy` and reads results after `done`.

## Interface
Parameters:
- Dbits, 32, operand width; HI and LO are each Dbits wide.

Ports:
- clock  in  1  system clock; everything updates on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to begin operation `op`; sampled only when idle.
- op  in  2  operation select:
  - 00 = MULTU
  - 01 = MULT (signed)
  - 10 = DIVU
  - 11 = DIV (signed)
- a  in  Dbits  first operand (multiplicand or dividend), from register file read port 1.
- b  in  Dbits  second operand (multiplier or divisor), from register file read port 2.
- wr_hi  in  1  load HI from `a` (MTHI); honoured only when idle.
- wr_lo  in  1  load LO from `a` (MTLO); honoured only when idle.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; HI/LO hold the new result.
- hi  out  Dbits  HI register: product upper half, or remainder.
- lo  out  Dbits  LO register: product lower half, or quotient.

## Operation
- States: IDLE, CALC, FIX.
- IDLE + start=1:
  - Latch the operation and sign flags.
  - Latch operands as |a| and |b| for signed ops, raw for unsigned ops.
  - Load the iteration counter with Dbits-1 and move to CALC.
- CALC:
  - Multiply: one shift-add step per cycle into a 2·Dbits accumulator.
  - Divide: one restoring shift-subtract step per cycle.
  - Counter reaches 0 → FIX.
- FIX:
  - Apply sign correction.
  - Write HI and LO together, pulse `done` and return to IDLE.
- Signed multiply: negate the 2·Dbits product when sign(a) ≠ sign(b).
- Signed divide:
  - Quotient is negated when the signs differ.
  - Remainder takes the sign of the dividend.
  - Quotient is truncated toward zero.
- Divisor 0:
  - LO = all ones and HI = a (original value), for both signed and unsigned.
  - Still takes the full latency.
- Signed overflow (most-negative / -1): LO = 0x80…0, HI = 0. This falls out of the magnitude path and needs no special case.
- `wr_hi` / `wr_lo`:
  - When idle and start=0, load the register from `a` on the next edge; both may be asserted together.
  - Ignored while busy.
  - Ignored in the same cycle as an accepted start, which has priority.
- `start` while busy: ignored; no queuing.
- Changes on `op`, `a` or `b` after the start cycle: no effect.
- HI and LO hold their value except on a FIX write or an honoured wr_hi/wr_lo.
- `reset` (including mid-operation):
  - state → IDLE; busy = 0, done = 0, hi = 0, lo = 0.
  - Any in-flight operation is discarded.

## Timing
- Cycle 0: `start` is sampled high in IDLE.
- Cycles 1..Dbits: CALC, busy = 1.
- Cycle Dbits+1: FIX, busy = 1.
- Cycle Dbits+2:
  - busy = 0, done = 1, hi/lo hold the new result.
  - A new start is accepted in this same cycle (back-to-back).
- With Dbits = 32, done appears in cycle 34.
- `busy` and `done` are registered state decodes with no combinational path from inputs.
- `done` is high for exactly one cycle per completed operation.
- MTHI/MTLO: the value is visible on hi/lo the cycle after the wr_* strobe.

## Structure
- Package `muldiv_pkg` holds:
  - enum `muldiv_op_t` (MULTU, MULT, DIVU, DIV) with the encodings above;
  - enum `muldiv_state_t` (IDLE, CALC, FIX).
- Single module, no sub-module. Datapath and FSM live together.
- Counter width is $clog2(Dbits).

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; done in cycle 34, busy high in cycles 1–33.
- MULT a=0xFFFFFFFD (-3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; then back-to-back MULT 0x7FFFFFFF × 2 issued in the done cycle → hi=0, lo=0xFFFFFFFE.
- DIVU 100/7 → lo=14, hi=2; DIV 0xFFFFFFF9 (-7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 5/0 → lo=0xFFFFFFFF, hi=5; DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Start while busy is ignored (result matches the first op only). Reset asserted in cycle 10 → next cycle busy=0, done=0, hi=lo=0; a fresh MULTU 3×4 then gives lo=12, hi=0.
- wr_lo with a=0x1234 in IDLE → lo=0x1234 next cycle. wr_hi together with an accepted start → HI write dropped. wr_hi during CALC → dropped.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: operation encodings
// as seen on the op port, and the controller states.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MULTU = 2'b00,
    MULT  = 2'b01,
    DIVU  = 2'b10,
    DIV   = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO result
// registers; signed ops run on magnitudes and are sign-corrected in FIX.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int Dbits = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [Dbits-1:0] a,
  input  logic [Dbits-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  output logic             busy,
  output logic             done,
  output logic [Dbits-1:0] hi,
  output logic [Dbits-1:0] lo
);

  localparam int CW = $clog2(Dbits);

  muldiv_state_t          r_state, w_state_next;
  muldiv_op_t             r_op;
  logic [CW-1:0]          r_cnt;
  logic [2*Dbits-1:0]     r_acc;
  logic [Dbits-1:0]       r_opnd;
  logic                   r_neg_q, r_neg_r, r_bzero, r_done;
  logic [Dbits-1:0]       r_hi, r_lo;

  logic                   w_is_div;
  logic                   w_a_neg, w_b_neg;
  logic [Dbits-1:0]       w_a_mag, w_b_mag;
  logic [Dbits:0]         w_mul_sum, w_div_top, w_div_diff;
  logic                   w_div_ok;
  logic [Dbits-1:0]       w_div_rem;
  logic [2*Dbits-1:0]     w_acc_next, w_prod;
  logic [Dbits-1:0]       w_quo, w_rem;

  assign w_is_div = (r_op == DIVU) || (r_op == DIV);
  assign w_a_neg  = op[0] & a[Dbits-1];
  assign w_b_neg  = op[0] & b[Dbits-1];
  assign w_a_mag  = w_a_neg ? -a : a;
  assign w_b_mag  = w_b_neg ? -b : b;

  // Multiply: r_acc = {partial product, remaining multiplier bits}.
  // Divide:   r_acc = {partial remainder, remaining dividend / quotient bits}.
  assign w_mul_sum  = {1'b0, r_acc[2*Dbits-1:Dbits]} + {1'b0, (r_acc[0] ? r_opnd : '0)};
  assign w_div_top  = r_acc[2*Dbits-1:Dbits-1];
  assign w_div_diff = w_div_top - {1'b0, r_opnd};
  assign w_div_ok   = ~w_div_diff[Dbits];
  assign w_div_rem  = w_div_ok ? w_div_diff[Dbits-1:0] : w_div_top[Dbits-1:0];
  assign w_acc_next = w_is_div ? {w_div_rem, r_acc[Dbits-2:0], w_div_ok}
                               : {w_mul_sum, r_acc[Dbits-1:1]};

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_acc[Dbits-1:0] : r_acc[Dbits-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*Dbits-1:Dbits] : r_acc[2*Dbits-1:Dbits];

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = CALC;
      CALC:    if (r_cnt == '0) w_state_next = FIX;
      FIX:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != IDLE);
    done = r_done;
    hi   = r_hi;
    lo   = r_lo;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_op    <= MULTU;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_opnd  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_bzero <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= (r_state == FIX);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op    <= muldiv_op_t'(op);
            r_cnt   <= CW'(Dbits - 1);
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_bzero <= (b == '0);
            r_opnd  <= op[1] ? w_b_mag : w_a_mag;
            r_acc   <= {{Dbits{1'b0}}, (op[1] ? w_a_mag : w_b_mag)};
          end else begin
            if (wr_hi) r_hi <= a;
            if (wr_lo) r_lo <= a;
          end
        end
        CALC: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt - CW'(1);
        end
        FIX: begin
          // Zero divisor leaves the dividend in the remainder path, so only
          // the quotient needs forcing to all ones.
          if (w_is_div) begin
            r_hi <= w_rem;
            r_lo <= r_bzero ? '1 : w_quo;
          end else begin
            {r_hi, r_lo} <= w_prod;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
